// File: rtl/base_arb_pkg.sv
// base_arb_pkg: shared helpers for the round-robin burst arbiter.
//   idx_w   - width of a requester index, clog2(ways) with a floor of 1
//   rr_pick - round-robin scan of a valid vector starting at ptr,
//             returns {found, index}
package base_arb_pkg;

    localparam int MAX_WAYS = 16;

    function automatic int idx_w(input int ways);
        return ($clog2(ways) < 1) ? 1 : $clog2(ways);
    endfunction

    // Scan ptr, ptr+1, ... modulo ways. The loop runs from the far end
    // back to ptr so that the last write is the first hit in scan order.
    function automatic logic [4:0] rr_pick(input logic [MAX_WAYS-1:0] v,
                                           input logic [3:0]          ptr,
                                           input int                  ways);
        logic [4:0] r;
        int         k;
        r = '0;
        for (int j = MAX_WAYS - 1; j >= 0; j--) begin
            if (j < ways) begin
                k = int'(ptr) + j;
                if (k >= ways) k = k - ways;
                if (v[k]) r = {1'b1, 4'(k)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/base_arb_rr_pick.sv
// base_arb_rr_pick: combinational round-robin selector.
//   v     - per-requester valid
//   ptr   - requester index with highest priority this cycle
//   grant - one-hot grant (all zero when nothing is valid)
//   idx   - index of the granted requester
//   any   - some requester is valid
module base_arb_rr_pick
    import base_arb_pkg::*;
#(
    parameter int ways = 4,
    parameter int iw   = idx_w(ways)
) (
    input  logic [0:ways-1] v,
    input  logic [iw-1:0]   ptr,
    output logic [0:ways-1] grant,
    output logic [iw-1:0]   idx,
    output logic            any
);

    logic [MAX_WAYS-1:0] v_ext;
    logic [3:0]          ptr_ext;
    logic [4:0]          pick;

    always_comb begin
        v_ext = '0;
        for (int k = 0; k < ways; k++) v_ext[k] = v[k];
        ptr_ext = 4'(ptr);
        pick    = rr_pick(v_ext, ptr_ext, ways);
        any     = pick[4];
        idx     = iw'(pick[3:0]);
        grant   = '0;
        for (int k = 0; k < ways; k++) grant[k] = pick[4] && (pick[3:0] == 4'(k));
    end

endmodule

// File: rtl/base_arb_rr_burp.sv
// base_arb_rr_burp: round-robin arbiter that keeps multi-beat packets
// together, with a registered main+skid output stage.
//   clk, reset      - clock, asynchronous active-low reset
//   i_v/i_d/i_e/i_r - per-requester valid, data, end-of-packet, ready
//   o_v/o_d/o_e/o_s - output valid, data, end-of-packet, source index
//   o_r             - downstream ready
// Ready upstream depends only on the registered skid flag, so o_r never
// reaches i_r combinationally; all outputs come straight from main.
module base_arb_rr_burp
    import base_arb_pkg::*;
#(
    parameter int ways  = 4,
    parameter int width = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [0:ways-1]         i_v,
    input  logic [0:ways*width-1]   i_d,
    input  logic [0:ways-1]         i_e,
    output logic [0:ways-1]         i_r,
    output logic                    o_v,
    output logic [0:width-1]        o_d,
    output logic                    o_e,
    output logic [0:idx_w(ways)-1]  o_s,
    input  logic                    o_r
);

    localparam int iw = idx_w(ways);

    logic [iw-1:0]    ptr, lock_idx, pick_idx, src;
    logic             lock, pick_any;
    logic [0:ways-1]  pick_grant, grant;
    logic             space, accept, drain;
    logic [0:width-1] in_d, main_d, skid_d;
    logic             in_e, main_v, main_e, skid_v, skid_e;
    logic [iw-1:0]    main_s, skid_s;

    base_arb_rr_pick #(.ways(ways), .iw(iw)) u_pick (
        .v     (i_v),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Gating with reset holds ready low during reset and lets requester 0
    // in on the very first cycle after release.
    assign space = reset & ~skid_v;

    // While locked the grant stays with the packet owner; if the owner
    // drops valid nobody else gets through.
    always_comb begin
        grant = pick_grant;
        src   = pick_idx;
        if (lock) begin
            src = lock_idx;
            for (int k = 0; k < ways; k++) grant[k] = i_v[k] && (lock_idx == iw'(k));
        end
    end

    assign i_r    = space ? grant : '0;
    assign accept = |i_r;
    assign drain  = main_v & o_r;

    always_comb begin
        in_d = '0;
        in_e = 1'b0;
        for (int k = 0; k < ways; k++) begin
            if (src == iw'(k)) begin
                in_d = i_d[k*width +: width];
                in_e = i_e[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            main_v   <= 1'b0;
            main_d   <= '0;
            main_e   <= 1'b0;
            main_s   <= '0;
            skid_v   <= 1'b0;
            skid_d   <= '0;
            skid_e   <= 1'b0;
            skid_s   <= '0;
        end else begin
            if (accept) begin
                if (in_e) begin
                    lock <= 1'b0;
                    ptr  <= (src == iw'(ways - 1)) ? '0 : src + 1'b1;
                end else begin
                    lock     <= 1'b1;
                    lock_idx <= src;
                end
            end
            // A full skid blocks acceptance, so only the skid-to-main move
            // can happen in that case.
            if (skid_v) begin
                if (drain) begin
                    main_d <= skid_d;
                    main_e <= skid_e;
                    main_s <= skid_s;
                    skid_v <= 1'b0;
                end
            end else if (accept) begin
                if (!main_v || drain) begin
                    main_v <= 1'b1;
                    main_d <= in_d;
                    main_e <= in_e;
                    main_s <= src;
                end else begin
                    skid_v <= 1'b1;
                    skid_d <= in_d;
                    skid_e <= in_e;
                    skid_s <= src;
                end
            end else if (drain) begin
                main_v <= 1'b0;
            end
        end
    end

    assign o_v = main_v;
    assign o_d = main_d;
    assign o_e = main_e;
    assign o_s = main_s;

endmodule

// File: tb/tb_base_arb_rr_burp.sv
module tb_base_arb_rr_burp;

    localparam int ways  = 4;
    localparam int width = 8;
    localparam int iw    = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [0:ways-1]        i_v, i_e, i_r;
    logic [0:ways*width-1]  i_d;
    logic                   o_v, o_e, o_r;
    logic [0:width-1]       o_d;
    logic [0:iw-1]          o_s;

    always #5 clk = ~clk;

    base_arb_rr_burp #(.ways(ways), .width(width)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_d   (i_d),
        .i_e   (i_e),
        .i_r   (i_r),
        .o_v   (o_v),
        .o_d   (o_d),
        .o_e   (o_e),
        .o_s   (o_s),
        .o_r   (o_r)
    );

    typedef struct {
        int               src;
        logic [0:width-1] d;
        logic             e;
    } beat_t;

    typedef struct {
        logic [0:ways-1] v;
        logic [0:ways-1] e;
        logic            orv;
        int              gnt;
        logic            ov;
        int              os;
    } vec_t;

    // Reference: the queue is the set of beats held by the block (its size
    // is the occupancy, its head is the beat on the output).
    beat_t            q[$];
    int               m_ptr, m_lsrc;
    bit               m_lock;
    logic [0:width-1] dval [ways];
    int               n_tests, n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:ways-1] onehot(input int g);
        logic [0:ways-1] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic int model_grant(input logic [0:ways-1] v);
        int k;
        if (q.size() >= 2) return -1;
        if (m_lock) return v[m_lsrc] ? m_lsrc : -1;
        for (int j = 0; j < ways; j++) begin
            k = (m_ptr + j) % ways;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ptr  = 0;
        m_lock = 0;
        m_lsrc = 0;
    endtask

    // Called just after a rising edge; returns what was sampled mid-cycle.
    task automatic step(input logic [0:ways-1] v, input logic [0:ways-1] e, input logic orv,
                        output logic [0:ways-1] ir_s, output logic ov_s, output logic [0:iw-1] os_s);
        int    g;
        beat_t b;
        i_v = v;
        i_e = e;
        o_r = orv;
        for (int k = 0; k < ways; k++) begin
            dval[k] = width'($urandom);
            i_d[k*width +: width] = dval[k];
        end
        @(negedge clk);
        g = model_grant(v);
        chk("i_r", i_r, onehot(g));
        chk("o_v", o_v, q.size() > 0);
        if (q.size() > 0) begin
            chk("o_s", o_s, q[0].src);
            chk("o_d", o_d, q[0].d);
            chk("o_e", o_e, q[0].e);
        end
        ir_s = i_r;
        ov_s = o_v;
        os_s = o_s;
        o_r = ~orv;
        #1;
        chk("i_r_indep_o_r", i_r, onehot(g));
        o_r = orv;
        @(posedge clk);
        if (q.size() > 0 && orv) void'(q.pop_front());
        if (g >= 0) begin
            b.src = g;
            b.d   = dval[g];
            b.e   = e[g];
            q.push_back(b);
            if (e[g]) begin
                m_lock = 0;
                m_ptr  = (g + 1) % ways;
            end else begin
                m_lock = 1;
                m_lsrc = g;
            end
        end
        #1;
    endtask

    vec_t            tbl[14];
    logic [0:ways-1] ir_s;
    logic            ov_s;
    logic [0:iw-1]   os_s;
    int              acc;
    logic [0:ways-1] rv, re;
    logic            ro;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        // Round-robin sweep, then a 3-beat packet from requester 2.
        tbl[0]  = '{4'b1111, 4'b1111, 1'b1,  0, 1'b0, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1,  1, 1'b1, 0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1,  2, 1'b1, 1};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1,  3, 1'b1, 2};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1,  0, 1'b1, 3};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1,  1, 1'b1, 0};
        tbl[6]  = '{4'b1111, 4'b1101, 1'b1,  2, 1'b1, 1};
        tbl[7]  = '{4'b1111, 4'b1101, 1'b1,  2, 1'b1, 2};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b1,  2, 1'b1, 2};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1,  3, 1'b1, 2};
        tbl[10] = '{4'b1111, 4'b1111, 1'b1,  0, 1'b1, 3};
        tbl[11] = '{4'b1111, 4'b1111, 1'b1,  1, 1'b1, 0};
        tbl[12] = '{4'b0000, 4'b0000, 1'b1, -1, 1'b1, 1};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, -1, 1'b0, 0};

        reset = 1'b0;
        i_v   = 4'b1111;
        i_e   = '0;
        i_d   = '0;
        o_r   = 1'b1;
        #2;
        chk("reset_o_v", o_v, 1'b0);
        chk("reset_i_r", i_r, 4'b0000);
        chk("reset_o_d", o_d, 8'h00);
        chk("reset_o_e", o_e, 1'b0);
        chk("reset_o_s", o_s, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].orv, ir_s, ov_s, os_s);
            chk("tbl_i_r", ir_s, onehot(tbl[i].gnt));
            chk("tbl_o_v", ov_s, tbl[i].ov);
            if (tbl[i].ov) chk("tbl_o_s", os_s, tbl[i].os);
        end

        // Downstream stalled: only main and skid fill, then ready drops.
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b0, ir_s, ov_s, os_s);
            acc += $countones(ir_s);
        end
        chk("stall_accepts", acc, 2);
        chk("stall_i_r", ir_s, 4'b0000);
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b1, ir_s, ov_s, os_s);

        // Only requester 3, single-beat packets: ptr wraps and 3 keeps winning.
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 4'b0001, 1'b1, ir_s, ov_s, os_s);
            chk("wrap_i_r", ir_s, 4'b0001);
            if (i > 0) chk("wrap_o_s", os_s, 2'd3);
        end
        step(4'b0000, 4'b0000, 1'b1, ir_s, ov_s, os_s);

        // Mid-packet reset with the skid full.
        step(4'b0100, 4'b0000, 1'b0, ir_s, ov_s, os_s);
        step(4'b0100, 4'b0000, 1'b0, ir_s, ov_s, os_s);
        chk("pre_reset_skid_full_i_r", i_r, 4'b0000);
        i_v = 4'b1111;
        #2 reset = 1'b0;
        #1;
        chk("midreset_o_v", o_v, 1'b0);
        chk("midreset_i_r", i_r, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        step(4'b1100, 4'b1100, 1'b1, ir_s, ov_s, os_s);
        chk("post_reset_grant0", ir_s, 4'b1000);
        step(4'b0000, 4'b0000, 1'b1, ir_s, ov_s, os_s);
        chk("post_reset_o_s", os_s, 2'd0);
        step(4'b0000, 4'b0000, 1'b1, ir_s, ov_s, os_s);

        for (int i = 0; i < 10000; i++) begin
            rv = 4'($urandom);
            for (int k = 0; k < ways; k++) re[k] = ($urandom_range(0, 9) < 4);
            ro = ($urandom_range(0, 9) < 7);
            step(rv, re, ro, ir_s, ov_s, os_s);
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 1'b1, ir_s, ov_s, os_s);
        chk("final_empty", o_v, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/base_arb_rr_burp.md
BASE_ARB_RR_BURP -- requirements
Module: base_arb_rr_burp

Interface
REQ-001 SHALL have parameter ways, default 4, number of requesting input streams (2..16).
REQ-002 SHALL have parameter width, default 1, data bits per beat.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous and active-low (0 = in reset).
REQ-005 SHALL have port i_v  input  [0:ways-1]  per-requester valid.
REQ-006 SHALL have port i_d  input  [0:ways*width-1]  per-requester data; requester k occupies bits k*width..k*width+width-1.
REQ-007 SHALL have port i_e  input  [0:ways-1]  per-requester end-of-packet flag, qualified by i_v.
REQ-008 SHALL have port i_r  output  [0:ways-1]  per-requester ready.
REQ-009 SHALL have port o_v  output  1  output valid.
REQ-010 SHALL have port o_d  output  [0:width-1]  output data.
REQ-011 SHALL have port o_e  output  1  end-of-packet of the output beat.
REQ-012 SHALL have port o_s  output  [0:$clog2(ways)-1]  index of the source requester of the output beat.
REQ-013 SHALL have port o_r  input  1  downstream ready.

Function
REQ-014 Transfer on any port SHALL occur when v and r are both 1 in the same cycle.
REQ-015 At most one i_r bit SHALL be 1 in any cycle; i_r[k] = grant[k] AND space.
REQ-016 space SHALL be a registered signal (skid holder empty); no combinational path from o_r to any i_r.
REQ-017 o_v, o_d, o_e, o_s SHALL be driven from registers only; no combinational path from any i_* to any o_*.
REQ-018 Output stage SHALL be a 2-entry main+skid buffer: accepted beat goes to main if main empty or draining this cycle, else to skid; space = skid empty.
REQ-019 Latency SHALL be one cycle: beat accepted in cycle t is presented on o_v in cycle t+1 if main was empty or drained at t.
REQ-020 Throughput SHALL be one beat per cycle with o_r held at 1.
REQ-021 When unlocked, grant SHALL pick the first k with i_v[k]=1 scanning ptr, ptr+1, ..., ptr+ways-1 modulo ways.
REQ-022 On acceptance of a beat from k with i_e[k]=0, the block SHALL lock to k; while locked, grant = k regardless of other i_v.
REQ-023 On acceptance of a beat from k with i_e[k]=1, the block SHALL clear lock and set ptr = (k+1) mod ways (wrap from ways-1 to 0).
REQ-024 ptr and lock SHALL NOT change in cycles without an accepted input beat.
REQ-025 While locked with i_v[k]=0, all i_r SHALL be 0; other requesters SHALL NOT be granted.
REQ-026 Simultaneous input accept and output drain in one cycle SHALL keep occupancy unchanged and preserve beat order.
REQ-027 With space=0 (skid full), i_r SHALL be 0 for all k; grant and lock state SHALL be retained.
REQ-028 Output order SHALL equal acceptance order; no beat dropped or duplicated.

Reset
REQ-029 While reset=0: o_v=0, i_r=0 (space forced 0), ptr=0, lock clear, main and skid empty.
REQ-030 Reset assertion mid-packet SHALL discard buffered beats and lock immediately (asynchronously).
REQ-031 First cycle after reset release: space=1; i_v[0]=1 receives i_r[0]=1 if asserted.
REQ-032 o_d, o_e, o_s SHALL have defined reset value 0.

Structure
REQ-033 A shared package base_arb_pkg SHALL hold the round-robin pick function and the index width helper (clog2 of ways, min 1).
REQ-034 Sub-module base_arb_rr_pick (combinational: i_v, ptr -> one-hot grant, index) SHALL be instantiated once; buffer and lock logic stay in the top.

Verification
REQ-035 ways=4, all i_v=1, i_e=1, o_r=1 from reset -> o_s sequence 0,1,2,3,0,... one beat per cycle, first o_v one cycle after first accept.
REQ-036 Requester 2 sends 3 beats (e=0,0,1) while 0,1,3 valid -> o_s = 2,2,2 contiguous, then 3,0,1; ptr=3 after packet.
REQ-037 o_r=0 for 5 cycles with all i_v=1 -> exactly 2 beats accepted, then i_r all 0; on o_r=1 beats drain in order, none lost.
REQ-038 Only requester 3 valid, ptr=3, single-beat packets -> ptr wraps to 0; next grant 3 again; o_s=3 each cycle.
REQ-039 Reset=0 asserted mid-packet with skid full -> same cycle o_v=0, i_r=0; after release, requester 0 wins over requester 1 (both valid).
REQ-040 Random i_v/i_e/o_r, 10k cycles -> per-source order preserved, packets never interleaved, no o_r-to-i_r combinational dependence (checked by assertion).
